lt24_pixel_writer: RTL and testbench

//  Responder/sink for the (xAddr, yAddr, pixelData, pixelWrite, pixelReady) pixel interface.

---
 rtl/lt24_pixel_writer.sv | 182 ++++++++++++++++++
 tb/tb_lt24_pixel_writer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lt24_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module   : lt24_pixel_writer
// Brief    : Turns accepted pixels into LT24 8080-style write cycles. A full
//            CASET/PASET/RAMWR address set is sent only when the pixel is not
//            where the panel's address counter will auto-increment to.
// Revision : 1.0  initial release
// ============================================================================
module lt24_pixel_writer #(
    parameter int WIDTH          = 240,
    parameter int HEIGHT         = 320,
    parameter int WR_LOW_CYCLES  = 2,
    parameter int WR_HIGH_CYCLES = 2
) (
    input  logic        clock,
    input  logic        resetApp_n,
    input  logic [7:0]  xAddr,
    input  logic [8:0]  yAddr,
    input  logic [15:0] pixelData,
    input  logic        pixelWrite,
    output logic        pixelReady,
    output logic        LT24CS_n,
    output logic        LT24RS,
    output logic        LT24Wr_n,
    output logic        LT24Rd_n,
    output logic [15:0] LT24Data
);

    localparam int          P_CYCLES  = WR_LOW_CYCLES + WR_HIGH_CYCLES;
    localparam int          PW        = $clog2(P_CYCLES + 1);
    localparam logic [3:0]  LAST_WORD = 4'd11;
    localparam logic [15:0] X_MAX     = 16'(WIDTH - 1);
    localparam logic [15:0] Y_MAX     = 16'(HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_SKIP = 2'd2
    } state_t;

    state_t state, state_next;

    logic [7:0]    x_lat;
    logic [8:0]    y_lat;
    logic [15:0]   d_lat;
    logic [3:0]    idx;
    logic [PW-1:0] phase;
    logic          addr_valid;
    logic [7:0]    nx, xs;
    logic [8:0]    ny, ys;

    logic          accept, out_of_range, hit, phase_last;
    logic [3:0]    start_idx;
    logic [16:0]   next_word;
    logic [7:0]    base_x;
    logic [8:0]    base_y;

    // Word i of the transfer as {RS, data}; index 11 is always the pixel word.
    function automatic logic [16:0] word_of(input logic [3:0]  i,
                                            input logic [7:0]  x,
                                            input logic [8:0]  y,
                                            input logic [15:0] d);
        case (i)
            4'd0:    word_of = {1'b0, 16'h002A};
            4'd1:    word_of = {1'b1, 16'h0000};
            4'd2:    word_of = {1'b1, 8'h00, x};
            4'd3:    word_of = {1'b1, 8'h00, X_MAX[15:8]};
            4'd4:    word_of = {1'b1, 8'h00, X_MAX[7:0]};
            4'd5:    word_of = {1'b0, 16'h002B};
            4'd6:    word_of = {1'b1, 15'h0000, y[8]};
            4'd7:    word_of = {1'b1, 8'h00, y[7:0]};
            4'd8:    word_of = {1'b1, 8'h00, Y_MAX[15:8]};
            4'd9:    word_of = {1'b1, 8'h00, Y_MAX[7:0]};
            4'd10:   word_of = {1'b0, 16'h002C};
            default: word_of = {1'b1, d};
        endcase
    endfunction

    assign LT24Rd_n     = 1'b1;
    assign accept       = (state == S_IDLE) && pixelWrite && pixelReady;
    assign out_of_range = (16'(xAddr) > X_MAX) || (16'(yAddr) > Y_MAX);
    assign hit          = addr_valid && (xAddr == nx) && (yAddr == ny);
    assign phase_last   = (phase == PW'(P_CYCLES - 1));
    assign start_idx    = hit ? LAST_WORD : 4'd0;
    assign base_x       = hit ? xs : xAddr;
    assign base_y       = hit ? ys : yAddr;

    always_comb begin
        next_word = word_of(idx + 4'd1, x_lat, y_lat, d_lat);
        if (state == S_IDLE) begin
            next_word = word_of(start_idx, xAddr, yAddr, pixelData);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (accept) state_next = out_of_range ? S_SKIP : S_SEND;
            S_SEND: if (phase_last && (idx == LAST_WORD)) state_next = S_IDLE;
            S_SKIP: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetApp_n) begin
        if (!resetApp_n) state <= S_IDLE;
        else             state <= state_next;
    end

    always_ff @(posedge clock or negedge resetApp_n) begin
        if (!resetApp_n) begin
            pixelReady <= 1'b0;
            LT24CS_n   <= 1'b1;
            LT24RS     <= 1'b1;
            LT24Wr_n   <= 1'b1;
            LT24Data   <= 16'h0000;
            x_lat      <= 8'h00;
            y_lat      <= 9'h000;
            d_lat      <= 16'h0000;
            idx        <= 4'd0;
            phase      <= '0;
            addr_valid <= 1'b0;
            nx         <= 8'h00;
            ny         <= 9'h000;
            xs         <= 8'h00;
            ys         <= 9'h000;
        end else begin
            LT24CS_n <= 1'b0;
            case (state)
                S_IDLE: begin
                    pixelReady <= 1'b1;
                    if (accept) begin
                        pixelReady <= 1'b0;
                        x_lat      <= xAddr;
                        y_lat      <= yAddr;
                        d_lat      <= pixelData;
                        if (!out_of_range) begin
                            // Track where the panel's address counter lands next.
                            xs         <= base_x;
                            ys         <= base_y;
                            addr_valid <= 1'b1;
                            if (16'(xAddr) < X_MAX) begin
                                nx <= xAddr + 8'd1;
                                ny <= yAddr;
                            end else if (16'(yAddr) < Y_MAX) begin
                                nx <= base_x;
                                ny <= yAddr + 9'd1;
                            end else begin
                                nx <= base_x;
                                ny <= base_y;
                            end
                            idx                <= start_idx;
                            phase              <= '0;
                            {LT24RS, LT24Data} <= next_word;
                            LT24Wr_n           <= 1'b0;
                        end
                    end
                end
                S_SEND: begin
                    if (phase_last) begin
                        phase <= '0;
                        if (idx == LAST_WORD) begin
                            pixelReady <= 1'b1;
                            LT24Wr_n   <= 1'b1;
                        end else begin
                            idx                <= idx + 4'd1;
                            {LT24RS, LT24Data} <= next_word;
                            LT24Wr_n           <= 1'b0;
                        end
                    end else begin
                        phase    <= phase + PW'(1);
                        LT24Wr_n <= !((phase + PW'(1)) < PW'(WR_LOW_CYCLES));
                    end
                end
                S_SKIP: pixelReady <= 1'b1;
                default: pixelReady <= 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lt24_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lt24_pixel_writer
// Brief    : Directed self-checking bench for lt24_pixel_writer (full-size
//            panel plus a 4x3 instance for the end-of-frame wrap).
// Revision : 1.0  initial release
// ============================================================================
module tb_lt24_pixel_writer;

    logic        clock = 1'b0;
    logic        resetApp_n;
    logic [7:0]  xAddr;
    logic [8:0]  yAddr;
    logic [15:0] pixelData;
    logic        pw1, pw2;
    logic        rdy1, cs1, rs1, wr1, rd1;
    logic        rdy2, cs2, rs2, wr2, rd2;
    logic [15:0] data1, data2;

    int tests  = 0;
    int failed = 0;
    bit sel    = 1'b0;

    always #5 clock = ~clock;

    lt24_pixel_writer dut1 (
        .clock(clock), .resetApp_n(resetApp_n), .xAddr(xAddr), .yAddr(yAddr),
        .pixelData(pixelData), .pixelWrite(pw1), .pixelReady(rdy1),
        .LT24CS_n(cs1), .LT24RS(rs1), .LT24Wr_n(wr1), .LT24Rd_n(rd1), .LT24Data(data1)
    );

    lt24_pixel_writer #(.WIDTH(4), .HEIGHT(3), .WR_LOW_CYCLES(2), .WR_HIGH_CYCLES(2)) dut2 (
        .clock(clock), .resetApp_n(resetApp_n), .xAddr(xAddr), .yAddr(yAddr),
        .pixelData(pixelData), .pixelWrite(pw2), .pixelReady(rdy2),
        .LT24CS_n(cs2), .LT24RS(rs2), .LT24Wr_n(wr2), .LT24Rd_n(rd2), .LT24Data(data2)
    );

    // Bus monitor: one entry per completed Wr_n low pulse.
    logic [16:0] words[$];
    int          lens[$];
    int          low_len = 0;
    logic [16:0] last_w;

    always @(negedge clock) begin
        if ((sel ? wr2 : wr1) === 1'b0) begin
            last_w  = sel ? {rs2, data2} : {rs1, data1};
            low_len = low_len + 1;
        end else if (low_len > 0) begin
            words.push_back(last_w);
            lens.push_back(low_len);
            low_len = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] exp_full(input int i, input logic [7:0] x,
                                             input logic [8:0] y, input logic [15:0] d);
        logic [15:0] xm, ym;
        xm = sel ? 16'd3 : 16'd239;
        ym = sel ? 16'd2 : 16'd319;
        case (i)
            0:  exp_full = {1'b0, 16'h002A};
            1:  exp_full = {1'b1, 16'h0000};
            2:  exp_full = {1'b1, 8'h00, x};
            3:  exp_full = {1'b1, 8'h00, xm[15:8]};
            4:  exp_full = {1'b1, 8'h00, xm[7:0]};
            5:  exp_full = {1'b0, 16'h002B};
            6:  exp_full = {1'b1, 15'h0000, y[8]};
            7:  exp_full = {1'b1, 8'h00, y[7:0]};
            8:  exp_full = {1'b1, 8'h00, ym[15:8]};
            9:  exp_full = {1'b1, 8'h00, ym[7:0]};
            10: exp_full = {1'b0, 16'h002C};
            default: exp_full = {1'b1, d};
        endcase
    endfunction

    function automatic logic rdy_sel();
        return sel ? rdy2 : rdy1;
    endfunction

    task automatic run_pixel(input logic [7:0] x, input logic [8:0] y, input logic [15:0] d,
                             input bit full, input bit oor);
        int lat;
        int n;
        check($sformatf("ready_before(%0d,%0d)", x, y), 32'(rdy_sel()), 32'd1);
        words.delete();
        lens.delete();
        low_len   = 0;
        xAddr     = x;
        yAddr     = y;
        pixelData = d;
        if (sel) pw2 = 1'b1; else pw1 = 1'b1;
        @(posedge clock);
        #1;
        pw1 = 1'b0;
        pw2 = 1'b0;
        xAddr     = 8'hA5;
        yAddr     = 9'h15A;
        pixelData = 16'hDEAD;
        lat = 1;
        while (rdy_sel() !== 1'b1 && lat < 300) begin
            @(posedge clock);
            #1;
            lat++;
        end
        n = oor ? 0 : (full ? 12 : 1);
        check($sformatf("latency(%0d,%0d)", x, y), 32'(lat), 32'(oor ? 2 : 1 + n * 4));
        check($sformatf("word_count(%0d,%0d)", x, y), 32'(words.size()), 32'(n));
        for (int i = 0; i < n && i < words.size(); i++) begin
            check($sformatf("word%0d(%0d,%0d)", i, x, y), 32'(words[i]),
                  32'(full ? exp_full(i, x, y, d) : {1'b1, d}));
            check($sformatf("wr_low_len%0d(%0d,%0d)", i, x, y), 32'(lens[i]), 32'd2);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 32'(rdy1), 32'd0);
        check({tag, "_cs_n"},  32'(cs1),  32'd1);
        check({tag, "_rs"},    32'(rs1),  32'd1);
        check({tag, "_wr_n"},  32'(wr1),  32'd1);
        check({tag, "_rd_n"},  32'(rd1),  32'd1);
        check({tag, "_data"},  32'(data1), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetApp_n = 1'b0;
        pw1 = 1'b0;
        pw2 = 1'b0;
        xAddr = 8'h00;
        yAddr = 9'h000;
        pixelData = 16'h0000;

        repeat (3) @(posedge clock);
        #1;
        check_reset_values("reset");
        #3 resetApp_n = 1'b1;
        @(posedge clock);
        #1;
        check("release_ready", 32'(rdy1), 32'd1);
        check("release_cs_n",  32'(cs1),  32'd0);
        check("release_ready2", 32'(rdy2), 32'd1);

        // First pixel always needs the full address set.
        run_pixel(8'd0, 9'd0, 16'hF920, 1'b1, 1'b0);
        run_pixel(8'd1, 9'd0, 16'h4DC4, 1'b0, 1'b0);

        repeat (3) @(posedge clock);
        #1;
        check("idle_cs_n", 32'(cs1),  32'd0);
        check("idle_wr_n", 32'(wr1),  32'd1);
        check("idle_rd_n", 32'(rd1),  32'd1);
        check("idle_hold", 32'({rs1, data1}), 32'h1_4DC4);

        // Window at column 200: stream to the edge, then wrap to the start column.
        run_pixel(8'd200, 9'd5, 16'h1234, 1'b1, 1'b0);
        for (int xx = 201; xx <= 239; xx++) begin
            run_pixel(8'(xx), 9'd5, 16'(xx * 131 + 7), 1'b0, 1'b0);
        end
        run_pixel(8'd200, 9'd6, 16'hBEEF, 1'b0, 1'b0);

        run_pixel(8'd5, 9'd5, 16'h0F0F, 1'b1, 1'b0);

        // Out-of-range requests leave the prediction intact.
        run_pixel(8'd240, 9'd0, 16'h5555, 1'b0, 1'b1);
        run_pixel(8'd6, 9'd5, 16'h6666, 1'b0, 1'b0);
        run_pixel(8'd0, 9'd320, 16'h7777, 1'b0, 1'b1);
        run_pixel(8'd7, 9'd5, 16'h8888, 1'b0, 1'b0);

        // Small panel: full frame, then the wrap back to the window start.
        sel = 1'b1;
        run_pixel(8'd0, 9'd0, 16'hA000, 1'b1, 1'b0);
        for (int yy = 0; yy < 3; yy++) begin
            for (int xx = 0; xx < 4; xx++) begin
                if (xx != 0 || yy != 0) begin
                    run_pixel(8'(xx), 9'(yy), 16'(16'hA000 + yy * 16 + xx), 1'b0, 1'b0);
                end
            end
        end
        run_pixel(8'd0, 9'd0, 16'hA0FF, 1'b0, 1'b0);
        run_pixel(8'd3, 9'd1, 16'hA0EE, 1'b1, 1'b0);
        sel = 1'b0;

        // Reset in the middle of word 4 of a full address set.
        xAddr = 8'd9;
        yAddr = 9'd9;
        pixelData = 16'h9999;
        pw1 = 1'b1;
        @(posedge clock);
        #1;
        pw1 = 1'b0;
        repeat (17) @(posedge clock);
        #1;
        check("mid_word4_wr_n", 32'(wr1), 32'd0);
        check("mid_word4_word", 32'({rs1, data1}), 32'h1_00EF);
        #2 resetApp_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(posedge clock);
        @(negedge clock);
        resetApp_n = 1'b1;
        @(posedge clock);
        #1;
        check("rerelease_ready", 32'(rdy1), 32'd1);
        run_pixel(8'd1, 9'd0, 16'hC3C3, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
